// File: rtl/psi_seq_ctrl.sv
// -----------------------------------------------------------------------------
// psi_seq_ctrl
//
// Sequential controller for the private-set-intersection datapath. The n
// parties' b-bit membership bitmaps arrive one per handshake on a shared input
// channel. Each accepted bitmap is folded into an AND accumulator. When all n
// bitmaps have been folded in, the block holds the intersection bitmap and its
// cardinality on a valid/ready output channel until downstream accepts it.
//
// Parameters
//   b  : bitmap width (b >= 1)
//   n  : parties per intersection (n >= 1)
//   The cardinality width is derived as $clog2(b+1). It is not overridable.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous, active-high reset; clears any round in progress
//   in_set     : current party's membership bitmap
//   in_valid   : in_set is valid
//   in_ready   : block accepts in_set this cycle (low while a result is held)
//   out_set    : intersection bitmap (meaningful only while out_valid)
//   out_count  : popcount of out_set (meaningful only while out_valid)
//   out_valid  : result valid
//   out_ready  : downstream accepts the result
//   party_idx  : number of sets accepted in the current round
//   busy       : a round is in progress (state != IDLE)
//   abort      : only with PSI_ABORT_EN defined. Returns to IDLE from any
//                state and drops any transfer or handshake in the same cycle.
//
// Configuration macro: PSI_ABORT_EN (adds the abort input).
// -----------------------------------------------------------------------------
module psi_seq_ctrl #(
  parameter int b = 10,
  parameter int n = 4
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef PSI_ABORT_EN
  input  logic                   abort,
`endif
  input  logic [b-1:0]           in_set,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [b-1:0]           out_set,
  output logic [$clog2(b+1)-1:0] out_count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(n):0]     party_idx,
  output logic                   busy
);

  localparam int CW = $clog2(b+1);
  localparam int PW = $clog2(n) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Population count of a bitmap. The sum never exceeds b, so it fits in CW
  // bits by construction.
  function automatic logic [CW-1:0] popcount(input logic [b-1:0] v);
    logic [CW-1:0] sum;
    sum = '0;
    for (int i = 0; i < b; i++) begin
      sum = sum + CW'(v[i]);
    end
    return sum;
  endfunction

  state_t          state_p0, state_nxt;
  logic [b-1:0]    acc_p0,   acc_nxt;
  logic [CW-1:0]   cnt_p0,   cnt_nxt;
  logic [PW-1:0]   idx_p0,   idx_nxt;
  logic            xfer;
  logic [b-1:0]    acc_and;

  assign in_ready  = (state_p0 != OUT);
  assign xfer      = in_valid & in_ready;
  assign acc_and   = acc_p0 & in_set;

  assign out_set   = acc_p0;
  assign out_count = cnt_p0;
  assign out_valid = (state_p0 == OUT);
  assign party_idx = idx_p0;
  assign busy      = (state_p0 != IDLE);

  // Next-state and accumulator update
  always_comb begin
    state_nxt = state_p0;
    acc_nxt   = acc_p0;
    cnt_nxt   = cnt_p0;
    idx_nxt   = idx_p0;

    unique case (state_p0)
      IDLE: begin
        if (xfer) begin
          acc_nxt = in_set;
          idx_nxt = PW'(1);
          if (n == 1) begin
            // A single-party round completes on its first transfer. The
            // count is captured on the same edge as the final acc.
            state_nxt = OUT;
            cnt_nxt   = popcount(in_set);
          end else begin
            state_nxt = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (xfer) begin
          acc_nxt = acc_and;
          idx_nxt = idx_p0 + PW'(1);
          if (idx_p0 == PW'(n - 1)) begin
            state_nxt = OUT;
            cnt_nxt   = popcount(acc_and);
          end
        end
      end

      OUT: begin
        // in_ready is low here, so in_valid is ignored. acc is left as is.
        if (out_ready) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase

`ifdef PSI_ABORT_EN
    // abort overrides any transfer or handshake in the same cycle.
    if (abort) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      acc_nxt   = acc_p0;
      cnt_nxt   = cnt_p0;
    end
`endif
  end

  // State register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      acc_p0   <= '0;
      cnt_p0   <= '0;
      idx_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      acc_p0   <= acc_nxt;
      cnt_p0   <= cnt_nxt;
      idx_p0   <= idx_nxt;
    end
  end

endmodule

// File: doc/psi_seq_ctrl.md
Name: psi_seq_ctrl

Overview:
- Sequential controller for the private-set-intersection datapath.
- Accepts the n parties' b-bit membership bitmaps one per handshake over a shared input channel and folds them into an internal AND accumulator.
- Once all n sets are in, it presents the intersection bitmap plus its cardinality on a valid/ready output channel.
- Sits between the party input multiplexer and the downstream result consumer; replaces the fully unrolled n-way AND when inputs arrive serially.

Parameters:
- b, 10, bitmap width (|sigma|), b >= 1
- n, 4, number of parties per intersection, n >= 1
- CW, $clog2(b+1), width of the cardinality output; derived, not overridden

Ports:
- clk  input  1  single clock, rising-edge
- rst  input  1  synchronous, active-high reset
- in_set  input  b  current party's membership bitmap
- in_valid  input  1  in_set is valid
- in_ready  output  1  block accepts in_set this cycle
- out_set  output  b  intersection bitmap
- out_count  output  CW  number of ones in out_set
- out_valid  output  1  out_set/out_count valid
- out_ready  input  1  downstream accepts result
- party_idx  output  $clog2(n)+1  number of sets accepted in the current round
- busy  output  1  round in progress (state != IDLE)

Behaviour:
- States:
  - IDLE: no set accepted yet.
  - ACCUM: 1..n-1 sets accepted.
  - OUT: result held.
- Reset (rst=1 at clk edge): state=IDLE; acc=0; out_count=0; party_idx=0; out_valid=0; busy=0. Reset has priority over every other event; reset mid-round or during OUT discards the partial or pending result.
- in_ready: 1 in IDLE and ACCUM, 0 in OUT. A transfer occurs when in_valid & in_ready are both high at the clock edge.
- Transfer in IDLE:
  - acc <= in_set; party_idx <= 1.
  - If n==1, go to OUT; otherwise go to ACCUM.
- Transfer in ACCUM:
  - acc <= acc & in_set; party_idx <= party_idx+1.
  - If party_idx == n-1 before the increment, go to OUT.
- out_count is registered in the same edge as the final acc update, as the popcount of the new acc value. Zero-extend the sum to CW bits; the maximum value b fits by construction.
- Latency: out_valid=1 in the cycle immediately after the n-th transfer.
- OUT:
  - out_set=acc and out_count stay stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: next state IDLE; party_idx <= 0; acc is retained but is don't-care.
  - No new input transfer is possible in the handshake cycle (in_ready=0). The first new transfer can occur the cycle after.
- out_valid is high only in OUT; out_set and out_count are don't-care outside OUT. Drive acc regardless, no X.
- in_valid held low: block stalls indefinitely in its current state; acc is unchanged.
- in_valid asserted while in OUT: ignored, not consumed.
- All-zero intersection: a normal result with out_count=0. No early termination; all n sets are still consumed.
- busy = (state != IDLE).

Optional Feature:
- Macro: PSI_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at a clock edge with rst=0 returns the block to IDLE, with party_idx=0 and out_valid=0 the next cycle, from any state. Any transfer or output handshake in that same cycle is discarded.
  - rst has priority over abort.
- Undefined: no abort port; a round can only complete or be cleared by rst.

Test Plan:
- b=10,n=4; sets 0x3FF,0x2AA,0x3F0,0x0F0 back-to-back, out_ready=1 -> out_valid 1 cycle after 4th transfer; out_set=0x0A0, out_count=2; party_idx 1,2,3,4.
- Same sets with in_valid gaps of 3 idle cycles between sets; out_ready=0 for 5 cycles -> same result, out_set stable all 5 cycles, in_ready=0 throughout OUT.
- Sets 0x001,0x002,0x3FF,0x3FF -> out_set=0x000, out_count=0; all 4 sets consumed.
- Two sets accepted, then rst pulse -> state IDLE, party_idx=0. Then sets 0x3FF x4 -> out_set=0x3FF, out_count=10 (no leak of the pre-reset acc).
- n=1 build: single transfer 0x155 -> out_valid next cycle, out_set=0x155, out_count=5.
- PSI_ABORT_EN: abort after 3rd transfer -> IDLE next cycle. Next round 0x3C3,0x3FF,0x0FF,0x3FF -> out_set=0x0C3, out_count=4.
